ma_decim_fifo: RTL
==================

// Module: ma_decim_fifo
// PURPOSE
//  Downstream stage of the recursive moving-average FIR; consumes its 16-bit signed
//  output stream (one sample per in_valid) and decimates it by a runtime factor.
//  Kept samples are buffered in a small FIFO and delivered over a valid/ready
//  handshake to the consumer (DAC/UART framer). Samples that arrive while the FIFO
//  is full are dropped and flagged.
// PARAMETERS
//  DW     16  sample width (signed, two's complement)
//  DEPTH  8   FIFO depth in words; power of two, >= 2
//  DEC_W  8   width of dec_factor
// PORTS
//  clk         in   1            clock, all logic on rising edge
//  reset_n     in   1            synchronous, active-low reset
//  in_valid    in   1            in_data carries a new filtered sample this cycle
//  in_data     in   DW           signed filtered sample (q_rma of the MA filter)
//  dec_factor  in   DEC_W        keep 1 of every dec_factor samples; 0 is treated as 1
//  out_ready   in   1            consumer accepts out_data this cycle
//  out_valid   out  1            out_data holds a valid buffered sample
//  out_data    out  DW           oldest buffered sample
//  fifo_level  out  clog2(DEPTH)+1  words currently stored (0..DEPTH)
//  overflow    out  1            sticky: a kept sample was dropped (FIFO full)
//  clr_ovf     in   1            clears overflow (and drop_cnt) next cycle
//  drop_cnt    out  16           dropped-sample count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (reset_n==0 at clk edge): dec_cnt=0, rd/wr ptrs=0, fifo_level=0,
//   out_valid=0, out_data=0, overflow=0, drop_cnt=0. Reset mid-operation discards
//   all buffered data; no partial words survive.
//  Decimator: dec_eff = (dec_factor==0) ? 1 : dec_factor. On each in_valid:
//   keep = (dec_cnt==0); dec_cnt <= (dec_cnt >= dec_eff-1) ? 0 : dec_cnt+1.
//   First valid sample after reset is always kept. '>=' compare ensures a factor
//   lowered mid-stream wraps on the next valid sample; no samples lost to a stuck count.
//   dec_cnt holds when in_valid==0.
//  Push = in_valid & keep & (!full | pop). Pop = out_valid & out_ready.
//   Full with simultaneous pop: push accepted, level unchanged.
//   Empty with push: word visible on out_data/out_valid the next cycle (latency 1,
//   no combinational in->out path). Push+pop at level 1: out_data updates to new word.
//  Drop = in_valid & keep & full & !pop -> overflow<=1 (sticky); sample discarded;
//   dec_cnt still advances. clr_ovf and drop in same cycle: overflow stays 1.
//  Handshake: out_data/out_valid stable while out_valid & !out_ready. out_valid
//   never deasserts without a pop. out_ready while empty: no effect.
//  Pointers: log2(DEPTH) bits, wrap modulo DEPTH; full/empty from fifo_level.
//  No arithmetic on sample values; data passes bit-exact.
// CONFIGURATION
//  MA_DECIM_DROPCNT_EN defined: drop_cnt increments on each drop, saturates at
//   16'hFFFF, cleared by clr_ovf (drop in clr cycle -> drop_cnt=1).
//  Not defined: drop_cnt tied to 16'd0, no counter logic; overflow unaffected.
// TESTING
//  1 dec_factor=1, DEPTH=8, 5 valid samples 100..104, out_ready=1 -> out 100..104
//    in order, each 1 cycle after its input; overflow=0.
//  2 dec_factor=4, 12 consecutive samples 0..11 -> out 0,4,8 only; fifo_level max 1.
//  3 dec_factor=0 -> behaves as 1: every sample delivered.
//  4 out_ready=0, dec_factor=1, 10 samples -8..1 -> level 8, overflow=1, drop_cnt=2
//    (macro on) / 0 (off); release ready -> out -8..-1, then empty.
//  5 Full FIFO, in_valid & out_ready same cycle -> push accepted, level stays 8,
//    overflow not set; out_data held stable while out_ready=0.
//  6 reset_n=0 for one cycle with level 5 -> out_valid=0, level=0, overflow=0;
//    next sample after reset is kept irrespective of dec_factor.

Source files
------------

// File: rtl/ma_decim_fifo.sv
// ma_decim_fifo: runtime decimator followed by a small FIFO with a
// valid/ready output, fed by the recursive moving-average FIR.
// Kept samples that find the FIFO full are dropped and flagged
// through the sticky overflow bit.
// Optional feature: define MA_DECIM_DROPCNT_EN to build the saturating
// dropped-sample counter on drop_cnt. Without it, drop_cnt reads zero.
module ma_decim_fifo #(
  parameter int DW    = 16,
  parameter int DEPTH = 8,
  parameter int DEC_W = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         in_valid,
  input  logic signed [DW-1:0]         in_data,
  input  logic        [DEC_W-1:0]      dec_factor,
  input  logic                         out_ready,
  output logic                         out_valid,
  output logic signed [DW-1:0]         out_data,
  output logic [$clog2(DEPTH):0]       fifo_level,
  output logic                         overflow,
  input  logic                         clr_ovf,
  output logic [15:0]                  drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic signed [DW-1:0] mem [DEPTH];
  logic [AW-1:0]        rd_ptr;
  logic [AW-1:0]        wr_ptr;
  logic [DEC_W-1:0]     dec_cnt;

  logic [DEC_W-1:0]     dec_eff;
  logic                 keep;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 drop;
  logic [AW-1:0]        rd_next;
  logic [LW-1:0]        remain;
  logic [LW-1:0]        level_next;

  // Handshake decode: decimator keep, push/pop/drop and next-state pointers.
  always_comb begin
    dec_eff    = (dec_factor == '0) ? DEC_W'(1) : dec_factor;
    keep       = (dec_cnt == '0);
    full       = (fifo_level == LW'(DEPTH));
    pop        = out_valid & out_ready;
    push       = in_valid & keep & (~full | pop);
    drop       = in_valid & keep & full & ~pop;
    rd_next    = pop ? rd_ptr + AW'(1) : rd_ptr;
    remain     = fifo_level - LW'(pop);
    level_next = remain + LW'(push);
  end

  // Decimation counter: advances only on valid samples; '>=' lets a
  // factor lowered mid-stream wrap immediately instead of counting up.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      dec_cnt <= '0;
    end else if (in_valid) begin
      if (dec_cnt >= dec_eff - DEC_W'(1)) dec_cnt <= '0;
      else                                dec_cnt <= dec_cnt + DEC_W'(1);
    end
  end

  // Storage array: plain write port, no reset needed on sample words.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // Pointers, level and registered head-of-queue output.
  // out_data is preloaded with the word that will be at the head after
  // this edge: the incoming sample if the queue would otherwise be empty,
  // else the stored word at the advanced read pointer. This keeps the
  // output registered with one cycle of latency and no in->out path.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_level <= '0;
      out_valid  <= 1'b0;
      out_data   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      rd_ptr     <= rd_next;
      fifo_level <= level_next;
      out_valid  <= (level_next != '0);
      if (remain == '0) begin
        if (push) out_data <= in_data;
      end else begin
        out_data <= mem[rd_next];
      end
    end
  end

  // Sticky overflow: a drop wins over a simultaneous clear.
  always_ff @(posedge clk) begin
    if (!reset_n)     overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

`ifdef MA_DECIM_DROPCNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Dropped-sample counter, saturating; a drop in the clear cycle counts as 1.
  always_ff @(posedge clk) begin
    if (!reset_n)     drop_cnt <= '0;
    else if (clr_ovf) drop_cnt <= drop ? 16'd1 : 16'd0;
    else if (drop)    drop_cnt <= sat_inc(drop_cnt);
  end
`else
  assign drop_cnt = 16'd0;
`endif

endmodule
